boid_state_ram: RTL and testbench

- Parametrised successor to the register-based boid test memory.
- Stores per-boid x, y, vx, vy, vx_acc and vy_acc in six RAM banks inferable as M10k, with one synchronous read port and one write port.
- Field widths and boid count are parameters.
- An integrated init FSM grid-fills all boids after reset or on request.
- Sits between the boid accelerator update pipeline and the VGA draw logic.

---
 rtl/boid_state_ram.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_boid_state_ram.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_state_ram.sv
`default_nettype none
// ============================================================================
// Module      : boid_state_ram
// Description : Per-boid state store sitting between the boid update pipeline
//               and the VGA draw logic. Six RAM banks (x, y, vx, vy, vx_acc,
//               vy_acc) with one synchronous read port and one masked write
//               port. An integrated init FSM grid-fills every boid after
//               reset or on a refill request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional build macro:
//   BOID_STATE_RAM_RDW_BYPASS_EN - a same-cycle read and write to the same
//                                  valid address returns the new data for the
//                                  written fields (zero added latency).
//                                  Undefined: read-old-data, no bypass mux.
// ----------------------------------------------------------------------------
// Ports:
//   clk            clock
//   reset          synchronous, active-low reset
//   refill_req     one-cycle pulse, re-initialises all boids when READY
//   is_refilling   high while the init FSM owns the RAM
//   rd_en/rd_addr  read request / boid index
//   rd_valid       read data valid, one cycle after an accepted read
//   *_out          read data, sign-extended to 32 bits, held between reads
//   wr_en/wr_addr  write request / boid index
//   wb_mask        per-field write enable [0]x [1]y [2]vx [3]vy [4]vx_acc
//                  [5]vy_acc
//   *_in           write data, low field-width bits stored
// ============================================================================
module boid_state_ram #(
  parameter int NUM_BOIDS = 8,
  parameter int X_W       = 28,
  parameter int Y_W       = 27,
  parameter int V_W       = 21,
  parameter int ACC_W     = 32,
  parameter int FRAC      = 16,
  parameter int GRID_COLS = 540,
  localparam int AW       = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          refill_req,
  output logic          is_refilling,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [31:0]   x_out,
  output logic [31:0]   y_out,
  output logic [31:0]   vx_out,
  output logic [31:0]   vy_out,
  output logic [31:0]   vx_acc_out,
  output logic [31:0]   vy_acc_out,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wb_mask,
  input  logic [31:0]   x_in,
  input  logic [31:0]   y_in,
  input  logic [31:0]   vx_in,
  input  logic [31:0]   vy_in,
  input  logic [31:0]   vx_acc_in,
  input  logic [31:0]   vy_acc_in
);

  // Init grid constants, kept 32 bits wide and truncated at the bank input.
  localparam logic [31:0]   c_BASE     = 32'(100 << FRAC);
  localparam logic [31:0]   c_STEP     = 32'(10 << FRAC);
  localparam logic [31:0]   c_VINIT    = 32'(4 << FRAC);
  localparam logic [31:0]   c_COL_LAST = 32'(GRID_COLS - 1);
  localparam logic [AW-1:0] c_LAST     = AW'(NUM_BOIDS - 1);
  localparam logic [AW:0]   c_NB       = (AW + 1)'(NUM_BOIDS);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_ctr;
  logic [31:0]   r_col;
  logic [31:0]   r_fill_x;
  logic [31:0]   r_fill_y;
  logic          r_is_refilling;

  // --------------------------------------------------------------------------
  // Init FSM. Column and row positions are tracked incrementally so the grid
  // coordinates need no divider or multiplier.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_FILL;
      r_ctr          <= '0;
      r_col          <= '0;
      r_fill_x       <= c_BASE;
      r_fill_y       <= c_BASE;
      r_is_refilling <= 1'b1;
    end else begin
      case (r_state)
        S_FILL: begin
          if (r_ctr == c_LAST) begin
            r_state        <= S_READY;
            r_is_refilling <= 1'b0;
          end
          r_ctr <= r_ctr + AW'(1);
          if (r_col == c_COL_LAST) begin
            r_col    <= '0;
            r_fill_x <= c_BASE;
            r_fill_y <= r_fill_y + c_STEP;
          end else begin
            r_col    <= r_col + 32'd1;
            r_fill_x <= r_fill_x + c_STEP;
          end
        end
        S_READY: begin
          if (refill_req) begin
            r_state        <= S_FILL;
            r_is_refilling <= 1'b1;
            r_ctr          <= '0;
            r_col          <= '0;
            r_fill_x       <= c_BASE;
            r_fill_y       <= c_BASE;
          end
        end
        default: begin
          r_state        <= S_FILL;
          r_is_refilling <= 1'b1;
        end
      endcase
    end
  end

  assign is_refilling = r_is_refilling;

  // --------------------------------------------------------------------------
  // Address range checks; a power-of-two depth can never be out of range.
  // --------------------------------------------------------------------------
  logic w_rd_inrange;
  logic w_wr_inrange;

  generate
    if (NUM_BOIDS == (1 << AW)) begin : g_pow2_depth
      assign w_rd_inrange = 1'b1;
      assign w_wr_inrange = 1'b1;
    end else begin : g_bounded_depth
      assign w_rd_inrange = ({1'b0, rd_addr} < c_NB);
      assign w_wr_inrange = ({1'b0, wr_addr} < c_NB);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Write-port arbitration: the fill engine owns the port during FILL and
  // external traffic is dropped.
  // --------------------------------------------------------------------------
  logic          w_fill;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [5:0]    w_we;
  logic [AW-1:0] w_waddr;
  logic [X_W-1:0]   w_wd_x;
  logic [Y_W-1:0]   w_wd_y;
  logic [V_W-1:0]   w_wd_vx;
  logic [V_W-1:0]   w_wd_vy;
  logic [ACC_W-1:0] w_wd_ax;
  logic [ACC_W-1:0] w_wd_ay;

  assign w_fill   = (r_state == S_FILL);
  assign w_wr_acc = wr_en && !w_fill && w_wr_inrange;
  assign w_rd_acc = rd_en && !w_fill;
  assign w_we     = w_fill ? 6'h3F : (w_wr_acc ? wb_mask : 6'h00);
  assign w_waddr  = w_fill ? r_ctr : wr_addr;
  assign w_wd_x   = w_fill ? r_fill_x[X_W-1:0]  : x_in[X_W-1:0];
  assign w_wd_y   = w_fill ? r_fill_y[Y_W-1:0]  : y_in[Y_W-1:0];
  assign w_wd_vx  = w_fill ? c_VINIT[V_W-1:0]   : vx_in[V_W-1:0];
  assign w_wd_vy  = w_fill ? c_VINIT[V_W-1:0]   : vy_in[V_W-1:0];
  assign w_wd_ax  = w_fill ? '0                 : vx_acc_in[ACC_W-1:0];
  assign w_wd_ay  = w_fill ? '0                 : vy_acc_in[ACC_W-1:0];

  // Upper input bits beyond the field widths are intentionally discarded.
  logic w_unused_bits;
  assign w_unused_bits = ^{x_in, y_in, vx_in, vy_in, vx_acc_in, vy_acc_in,
                           r_fill_x, r_fill_y};

  // --------------------------------------------------------------------------
  // RAM banks: one simple-dual-port bank per field, no reset so they map onto
  // block RAM. Each bank has its own process to keep inference clean.
  // --------------------------------------------------------------------------
  logic [X_W-1:0]   r_mem_x  [NUM_BOIDS];
  logic [Y_W-1:0]   r_mem_y  [NUM_BOIDS];
  logic [V_W-1:0]   r_mem_vx [NUM_BOIDS];
  logic [V_W-1:0]   r_mem_vy [NUM_BOIDS];
  logic [ACC_W-1:0] r_mem_ax [NUM_BOIDS];
  logic [ACC_W-1:0] r_mem_ay [NUM_BOIDS];

  logic [X_W-1:0]   r_rd_x;
  logic [Y_W-1:0]   r_rd_y;
  logic [V_W-1:0]   r_rd_vx;
  logic [V_W-1:0]   r_rd_vy;
  logic [ACC_W-1:0] r_rd_ax;
  logic [ACC_W-1:0] r_rd_ay;

  logic w_rd_mem;
  assign w_rd_mem = w_rd_acc && w_rd_inrange;

  always_ff @(posedge clk) begin
    if (w_we[0]) r_mem_x[w_waddr] <= w_wd_x;
    if (w_rd_mem) r_rd_x <= r_mem_x[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (w_we[1]) r_mem_y[w_waddr] <= w_wd_y;
    if (w_rd_mem) r_rd_y <= r_mem_y[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (w_we[2]) r_mem_vx[w_waddr] <= w_wd_vx;
    if (w_rd_mem) r_rd_vx <= r_mem_vx[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (w_we[3]) r_mem_vy[w_waddr] <= w_wd_vy;
    if (w_rd_mem) r_rd_vy <= r_mem_vy[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (w_we[4]) r_mem_ax[w_waddr] <= w_wd_ax;
    if (w_rd_mem) r_rd_ax <= r_mem_ax[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (w_we[5]) r_mem_ay[w_waddr] <= w_wd_ay;
    if (w_rd_mem) r_rd_ay <= r_mem_ay[rd_addr];
  end

  // --------------------------------------------------------------------------
  // Read control. r_zero forces the outputs to 0 after reset and after an
  // out-of-range read, leaving the unreset bank output registers untouched.
  // Every register here only updates on an accepted read, so outputs hold.
  // --------------------------------------------------------------------------
  logic r_rd_valid;
  logic r_zero;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_zero <= !w_rd_inrange;
      end
    end
  end

  assign rd_valid = r_rd_valid;

  logic [X_W-1:0]   w_q_x;
  logic [Y_W-1:0]   w_q_y;
  logic [V_W-1:0]   w_q_vx;
  logic [V_W-1:0]   w_q_vy;
  logic [ACC_W-1:0] w_q_ax;
  logic [ACC_W-1:0] w_q_ay;

`ifdef BOID_STATE_RAM_RDW_BYPASS_EN
  // Captures the write data of a colliding write alongside the old read data;
  // the per-field select then picks the new value for written fields only.
  logic             w_rdw;
  logic [5:0]       r_byp_sel;
  logic [X_W-1:0]   r_byp_x;
  logic [Y_W-1:0]   r_byp_y;
  logic [V_W-1:0]   r_byp_vx;
  logic [V_W-1:0]   r_byp_vy;
  logic [ACC_W-1:0] r_byp_ax;
  logic [ACC_W-1:0] r_byp_ay;

  assign w_rdw = w_rd_acc && w_wr_acc && (rd_addr == wr_addr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_byp_sel <= '0;
    end else if (w_rd_acc) begin
      r_byp_sel <= w_rdw ? wb_mask : 6'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rdw) begin
      r_byp_x  <= w_wd_x;
      r_byp_y  <= w_wd_y;
      r_byp_vx <= w_wd_vx;
      r_byp_vy <= w_wd_vy;
      r_byp_ax <= w_wd_ax;
      r_byp_ay <= w_wd_ay;
    end
  end

  assign w_q_x  = r_byp_sel[0] ? r_byp_x  : r_rd_x;
  assign w_q_y  = r_byp_sel[1] ? r_byp_y  : r_rd_y;
  assign w_q_vx = r_byp_sel[2] ? r_byp_vx : r_rd_vx;
  assign w_q_vy = r_byp_sel[3] ? r_byp_vy : r_rd_vy;
  assign w_q_ax = r_byp_sel[4] ? r_byp_ax : r_rd_ax;
  assign w_q_ay = r_byp_sel[5] ? r_byp_ay : r_rd_ay;
`else
  assign w_q_x  = r_rd_x;
  assign w_q_y  = r_rd_y;
  assign w_q_vx = r_rd_vx;
  assign w_q_vy = r_rd_vy;
  assign w_q_ax = r_rd_ax;
  assign w_q_ay = r_rd_ay;
`endif

  // Sign-extend each field from its MSB up to 32 bits.
  assign x_out      = r_zero ? 32'd0 : 32'($signed(w_q_x));
  assign y_out      = r_zero ? 32'd0 : 32'($signed(w_q_y));
  assign vx_out     = r_zero ? 32'd0 : 32'($signed(w_q_vx));
  assign vy_out     = r_zero ? 32'd0 : 32'($signed(w_q_vy));
  assign vx_acc_out = r_zero ? 32'd0 : 32'($signed(w_q_ax));
  assign vy_acc_out = r_zero ? 32'd0 : 32'($signed(w_q_ay));

endmodule
`default_nettype wire

// File: tb/tb_boid_state_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_boid_state_ram
// Description : Self-checking bench for boid_state_ram. An 8-boid instance
//               takes table-driven read/write vectors plus hand sequences for
//               fill, refill and reset-mid-fill; a 6-boid instance sharing the
//               same inputs covers out-of-range reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boid_state_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        refill_req;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [5:0]  wb_mask;
  logic [31:0] x_in, y_in, vx_in, vy_in, vx_acc_in, vy_acc_in;

  logic        is_ref8, rd_valid8;
  logic [31:0] x8, y8, vx8, vy8, ax8, ay8;
  logic        is_ref6, rd_valid6;
  logic [31:0] x6, y6, vx6, vy6, ax6, ay6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  boid_state_ram #(.NUM_BOIDS(8), .GRID_COLS(4)) dut (
    .clk(clk), .reset(reset), .refill_req(refill_req), .is_refilling(is_ref8),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid8),
    .x_out(x8), .y_out(y8), .vx_out(vx8), .vy_out(vy8),
    .vx_acc_out(ax8), .vy_acc_out(ay8),
    .wr_en(wr_en), .wr_addr(wr_addr), .wb_mask(wb_mask),
    .x_in(x_in), .y_in(y_in), .vx_in(vx_in), .vy_in(vy_in),
    .vx_acc_in(vx_acc_in), .vy_acc_in(vy_acc_in)
  );

  boid_state_ram #(.NUM_BOIDS(6), .GRID_COLS(4)) dut6 (
    .clk(clk), .reset(reset), .refill_req(refill_req), .is_refilling(is_ref6),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid6),
    .x_out(x6), .y_out(y6), .vx_out(vx6), .vy_out(vy6),
    .vx_acc_out(ax6), .vy_acc_out(ay6),
    .wr_en(wr_en), .wr_addr(wr_addr), .wb_mask(wb_mask),
    .x_in(x_in), .y_in(y_in), .vx_in(vx_in), .vy_in(vy_in),
    .vx_acc_in(vx_acc_in), .vy_acc_in(vy_acc_in)
  );

  typedef struct packed {
    logic             wr;
    logic [2:0]       wa;
    logic [5:0]       mask;
    logic [5:0][31:0] din;
    logic             rd;
    logic [2:0]       ra;
    logic [5:0][31:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

`ifdef BOID_STATE_RAM_RDW_BYPASS_EN
  localparam logic [31:0] RDW_X = 32'h0001_0000;
`else
  localparam logic [31:0] RDW_X = 32'h0064_0000;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] out8(input int k);
    case (k)
      0: return x8;
      1: return y8;
      2: return vx8;
      3: return vy8;
      4: return ax8;
      default: return ay8;
    endcase
  endfunction

  function automatic logic [31:0] out6(input int k);
    case (k)
      0: return x6;
      1: return y6;
      2: return vx6;
      3: return vy6;
      4: return ax6;
      default: return ay6;
    endcase
  endfunction

  function automatic vec_t mk(
    input logic wr, input logic [2:0] wa, input logic [5:0] m,
    input logic [31:0] x, input logic [31:0] y, input logic [31:0] vx,
    input logic [31:0] vy, input logic [31:0] ax, input logic [31:0] ay,
    input logic rd, input logic [2:0] ra,
    input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] evx,
    input logic [31:0] evy, input logic [31:0] eax, input logic [31:0] eay);
    vec_t v;
    v.wr = wr; v.wa = wa; v.mask = m;
    v.din[0] = x; v.din[1] = y; v.din[2] = vx;
    v.din[3] = vy; v.din[4] = ax; v.din[5] = ay;
    v.rd = rd; v.ra = ra;
    v.exp[0] = ex; v.exp[1] = ey; v.exp[2] = evx;
    v.exp[3] = evy; v.exp[4] = eax; v.exp[5] = eay;
    return v;
  endfunction

  // Called at #1 after a posedge; occupies exactly one clock.
  task automatic do_read(input logic [2:0] a);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [5:0] m,
                          input logic [31:0] x, input logic [31:0] y);
    wr_en = 1'b1; wr_addr = a; wb_mask = m; x_in = x; y_in = y;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wr_en = v.wr; wr_addr = v.wa; wb_mask = v.mask;
    x_in = v.din[0]; y_in = v.din[1]; vx_in = v.din[2];
    vy_in = v.din[3]; vx_acc_in = v.din[4]; vy_acc_in = v.din[5];
    rd_en = v.rd; rd_addr = v.ra;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk($sformatf("v%0d_rd_valid", idx), {31'd0, rd_valid8}, {31'd0, v.rd});
    if (v.rd) begin
      for (int k = 0; k < 6; k++)
        chk($sformatf("v%0d_field%0d", idx, k), out8(k), v.exp[k]);
    end
  endtask

  // Counts is_refilling-high observations of both instances, starting at the
  // current one; a refill_req pulse mid-fill must not extend the fill.
  task automatic count_fill(input string nm, input int e8, input int e6);
    int n8;
    int n6;
    n8 = 0;
    n6 = 0;
    for (int c = 0; c < 24; c++) begin
      if (!is_ref8 && !is_ref6) break;
      if (is_ref8) n8++;
      if (is_ref6) n6++;
      refill_req = (c == 3);
      @(posedge clk); #1;
    end
    refill_req = 1'b0;
    chk({nm, "_len8"}, 32'(n8), 32'(e8));
    chk({nm, "_len6"}, 32'(n6), 32'(e6));
  endtask

  initial begin
    // Boid i grid (4 columns): x = 100+10*(i%4), y = 100+10*(i/4), <<16.
    vecs[0]  = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 0, 32'h0064_0000, 32'h0064_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);
    vecs[1]  = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 5, 32'h006E_0000, 32'h006E_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);
    vecs[2]  = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 1, 32'h006E_0000, 32'h0064_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);
    vecs[3]  = mk(1, 3, 6'h01, 32'hFFF8_0000, 32'h1234_5678, 32'h1111_1111, 32'h1111_1111,
                  32'h1111_1111, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 3, 32'hFFF8_0000, 32'h0064_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);
    vecs[5]  = mk(1, 2, 6'h04, 0, 0, 32'h0010_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 2, 32'h0078_0000, 32'h0064_0000, 32'hFFF0_0000, 32'h0004_0000, 0, 0);
    vecs[7]  = mk(1, 6, 6'h30, 32'hDEAD_BEEF, 0, 0, 0, 32'h8000_0001, 32'h7FFF_FFFF,
                  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 6, 32'h0078_0000, 32'h006E_0000, 32'h0004_0000, 32'h0004_0000,
                  32'h8000_0001, 32'h7FFF_FFFF);
    vecs[9]  = mk(1, 0, 6'h0A, 0, 32'h0400_0001, 0, 32'h000F_FFFF, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 0, 32'h0064_0000, 32'hFC00_0001, 32'h0004_0000, 32'h000F_FFFF, 0, 0);
    vecs[11] = mk(1, 5, 6'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 5, 32'h006E_0000, 32'h006E_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);
    vecs[13] = mk(1, 4, 6'h01, 32'h0001_0000, 32'h5555_5555, 0, 0, 0, 0,
                  1, 4, RDW_X, 32'h006E_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);
    vecs[14] = mk(0, 0, 6'h00, 0, 0, 0, 0, 0, 0,
                  1, 4, 32'h0001_0000, 32'h006E_0000, 32'h0004_0000, 32'h0004_0000, 0, 0);

    reset = 1'b0; refill_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wb_mask = '0;
    x_in = '0; y_in = '0; vx_in = '0; vy_in = '0; vx_acc_in = '0; vy_acc_in = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_is_refilling", {31'd0, is_ref8}, 32'd1);
    chk("rst_rd_valid", {31'd0, rd_valid8}, 32'd0);
    chk("rst_x_out", x8, 32'd0);
    chk("rst_vy_acc_out", ay8, 32'd0);

    // Release reset with a write to boid 1 and a read pending through the fill
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wb_mask = 6'h3F; rd_en = 1'b1; rd_addr = 3'd1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("fill_is_ref8_c%0d", i), {31'd0, is_ref8}, {31'd0, (i < 8)});
      chk($sformatf("fill_rd_valid_c%0d", i), {31'd0, rd_valid8}, 32'd0);
      if (i <= 6)
        chk($sformatf("fill_is_ref6_c%0d", i), {31'd0, is_ref6}, {31'd0, (i < 6)});
    end
    wr_en = 1'b0; rd_en = 1'b0;

    for (int v = 0; v < NV; v++) run_vec(vecs[v], v);

    // rd_valid is a single-cycle pulse and outputs hold afterwards
    do_read(3'd3);
    chk("pulse_rd_valid", {31'd0, rd_valid8}, 32'd1);
    chk("pulse_x", x8, 32'hFFF8_0000);
    @(posedge clk); #1;
    chk("pulse_rd_valid_drop", {31'd0, rd_valid8}, 32'd0);
    chk("hold_x", x8, 32'hFFF8_0000);

    // Refill restores a modified boid
    do_write(3'd7, 6'h03, 32'd0, 32'd0);
    do_read(3'd7);
    chk("mod7_x", x8, 32'd0);
    refill_req = 1'b1;
    @(posedge clk); #1;
    refill_req = 1'b0;
    count_fill("refill", 8, 6);
    do_read(3'd7);
    chk("refill7_x", x8, 32'h0082_0000);
    chk("refill7_y", y8, 32'h006E_0000);
    do_read(3'd3);
    chk("refill3_x", x8, 32'h0082_0000);

    // Reset at fill counter 3 restarts a full fill
    refill_req = 1'b1;
    @(posedge clk); #1;
    refill_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_x_out", x8, 32'd0);
    chk("rstmid_vx_out", vx8, 32'd0);
    chk("rstmid_is_ref", {31'd0, is_ref8}, 32'd1);
    reset = 1'b1;
    count_fill("rst_mid", 8, 6);
    do_read(3'd4);
    chk("rstmid4_x", x8, 32'h0064_0000);
    chk("rstmid4_vy", vy8, 32'h0004_0000);

    // Out-of-range read on the 6-boid instance
    do_read(3'd2);
    chk("nb6_in_x", x6, 32'h0078_0000);
    do_read(3'd7);
    chk("nb6_oor_rd_valid", {31'd0, rd_valid6}, 32'd1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("nb6_oor_field%0d", k), out6(k), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
